// File: rtl/fpsqrt_pkg.sv
// Shared types and constants for the fpsqrt issue buffer: format/rounding encodings,
// the buffered request record and the issue FSM state type.
package fpsqrt_pkg;

    localparam logic [1:0] FP_FMT_FP16 = 2'd0;
    localparam logic [1:0] FP_FMT_FP32 = 2'd1;
    localparam logic [1:0] FP_FMT_FP64 = 2'd2;
    localparam logic [1:0] FP_FMT_RSVD = 2'd3;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    localparam logic [4:0] FFLAGS_NV = 5'b10000;

    localparam int FPSQRT_TAG_W = 4;
    typedef logic [FPSQRT_TAG_W-1:0] fpsqrt_tag_t;

    typedef struct packed {
        logic [63:0] op;
        logic [1:0]  fmt;
        logic [2:0]  rm;
        fpsqrt_tag_t tag;
    } fpsqrt_req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        LOCAL = 2'd3
    } issue_state_e;

endpackage

// File: rtl/fpsqrt_req_fifo.sv
// Flop-based request FIFO with wrap-bit pointers; flush empties it in one cycle.
module fpsqrt_req_fifo
    import fpsqrt_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  fpsqrt_req_t              push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output fpsqrt_req_t              head_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    fpsqrt_req_t  mem_q [DEPTH];
    logic [AW:0]  wptr_q;
    logic [AW:0]  rptr_q;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count_o = wptr_q - rptr_q;
    assign head_o  = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_i && !full_o) begin
                mem_q[wptr_q[AW-1:0]] <= push_data_i;
                wptr_q <= wptr_q + PTR_ONE;
            end
            if (pop_i && !empty_o) begin
                rptr_q <= rptr_q + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/fpsqrt_issue_buf.sv
// Request buffer and single-issue front end for fpsqrt_scalar_r16.
// Optional FPSQRT_ISSUE_BYPASS_EN lets a request skip an empty FIFO and start the unit directly.
module fpsqrt_issue_buf
    import fpsqrt_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = fpsqrt_pkg::FPSQRT_TAG_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [63:0]              req_op_i,
    input  logic [1:0]               req_fp_format_i,
    input  logic [2:0]               req_rm_i,
    input  logic [TAG_W-1:0]         req_tag_i,
    input  logic                     flush_i,
    output logic                     sqrt_start_valid_o,
    input  logic                     sqrt_start_ready_i,
    output logic [63:0]              sqrt_op_o,
    output logic [1:0]               sqrt_fp_format_o,
    output logic [2:0]               sqrt_rm_o,
    output logic                     sqrt_flush_o,
    input  logic                     sqrt_finish_valid_i,
    output logic                     sqrt_finish_ready_o,
    input  logic [63:0]              sqrt_res_i,
    input  logic [4:0]               sqrt_fflags_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [63:0]              rsp_res_o,
    output logic [4:0]               rsp_fflags_o,
    output logic [TAG_W-1:0]         rsp_tag_o,
    output logic [$clog2(DEPTH):0]   count_o
);

`ifdef FPSQRT_ISSUE_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    issue_state_e      state_q, state_d;
    logic [TAG_W-1:0]  inflight_tag_q, inflight_tag_d;
    logic [TAG_W-1:0]  local_tag_q, local_tag_d;
    logic              sqrt_flush_q;

    fpsqrt_req_t       push_data;
    fpsqrt_req_t       fifo_head;
    logic              fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic              bypass_hs;

    assign push_data.op  = req_op_i;
    assign push_data.fmt = req_fp_format_i;
    assign push_data.rm  = req_rm_i;
    assign push_data.tag = fpsqrt_tag_t'(req_tag_i);

    assign req_ready_o  = !fifo_full;
    assign fifo_push    = req_valid_i && !fifo_full && !flush_i && !bypass_hs;
    assign sqrt_flush_o = sqrt_flush_q;

    fpsqrt_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i (push_data),
        .pop_i       (fifo_pop),
        .flush_i     (flush_i),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .count_o     (count_o)
    );

    always_comb begin
        state_d             = state_q;
        inflight_tag_d      = inflight_tag_q;
        local_tag_d         = local_tag_q;
        fifo_pop            = 1'b0;
        bypass_hs           = 1'b0;
        sqrt_start_valid_o  = 1'b0;
        sqrt_op_o           = '0;
        sqrt_fp_format_o    = '0;
        sqrt_rm_o           = '0;
        sqrt_finish_ready_o = 1'b0;
        rsp_valid_o         = 1'b0;
        rsp_res_o           = '0;
        rsp_fflags_o        = '0;
        rsp_tag_o           = '0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    if (fifo_head.fmt == FP_FMT_RSVD) begin
                        fifo_pop    = 1'b1;
                        local_tag_d = TAG_W'(fifo_head.tag);
                        state_d     = LOCAL;
                    end else begin
                        state_d = ISSUE;
                    end
                end else if (BYPASS_EN && req_valid_i && (req_fp_format_i != FP_FMT_RSVD)
                             && !sqrt_flush_q) begin
                    // The unit is still being flushed while sqrt_flush_q is high.
                    sqrt_start_valid_o = 1'b1;
                    sqrt_op_o          = req_op_i;
                    sqrt_fp_format_o   = req_fp_format_i;
                    sqrt_rm_o          = req_rm_i;
                    if (sqrt_start_ready_i) begin
                        bypass_hs      = 1'b1;
                        inflight_tag_d = req_tag_i;
                        state_d        = WAIT;
                    end
                end
            end
            ISSUE: begin
                sqrt_start_valid_o = 1'b1;
                sqrt_op_o          = fifo_head.op;
                sqrt_fp_format_o   = fifo_head.fmt;
                sqrt_rm_o          = fifo_head.rm;
                if (sqrt_start_ready_i) begin
                    fifo_pop       = 1'b1;
                    inflight_tag_d = TAG_W'(fifo_head.tag);
                    state_d        = WAIT;
                end
            end
            WAIT: begin
                rsp_valid_o         = sqrt_finish_valid_i;
                sqrt_finish_ready_o = rsp_ready_i;
                rsp_res_o           = sqrt_res_i;
                rsp_fflags_o        = sqrt_fflags_i;
                rsp_tag_o           = inflight_tag_q;
                if (sqrt_finish_valid_i && rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            LOCAL: begin
                rsp_valid_o  = 1'b1;
                rsp_fflags_o = FFLAGS_NV;
                rsp_tag_o    = local_tag_q;
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush kills handshakes in the same cycle so no flushed result escapes.
        if (flush_i) begin
            state_d             = IDLE;
            fifo_pop            = 1'b0;
            bypass_hs           = 1'b0;
            sqrt_start_valid_o  = 1'b0;
            sqrt_finish_ready_o = 1'b0;
            rsp_valid_o         = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            inflight_tag_q <= '0;
            local_tag_q    <= '0;
            sqrt_flush_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            inflight_tag_q <= inflight_tag_d;
            local_tag_q    <= local_tag_d;
            sqrt_flush_q   <= flush_i;
        end
    end

endmodule
